// File: rtl/boot_loader_if.sv
// boot_loader_if: host byte stream (valid/ready) plus the icache boot port.
// The loader sits on the slave side; the host/processor side uses master.
interface boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              src_valid;
  logic [7:0]        src_data;
  logic              src_ready;
  logic              boot_up;
  logic [ADDR_W-1:0] boot_addr;
  logic [31:0]       boot_datai;
  logic              boot_web;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready,
    input  boot_up,
    input  boot_addr,
    input  boot_datai,
    input  boot_web
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready,
    output boot_up,
    output boot_addr,
    output boot_datai,
    output boot_web
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: collects host bytes four at a time into big-endian 32-bit
// instructions and writes them to consecutive icache words from address 0,
// holding the processor in boot (boot_up) for the whole load.
// Optional feature macro: BOOT_CHECKSUM_EN -- after the last word a 32-bit
// checksum (XOR of all written words) is received and compared; a mismatch
// sets err. Without the macro err is tied low and there is no CHECK state.
module boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [ADDR_W:0] load_len_i,
  boot_loader_if.slave    bus,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSEMBLE = 3'd1,
    ST_WRITE    = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    ST_CHECK    = 3'd3,
`endif
    ST_FINISH   = 3'd4
  } state_t;

  // Append one byte below the bytes already collected (first byte ends up in [31:24]).
  function automatic logic [31:0] pack_byte(input logic [23:0] partial, input logic [7:0] data);
    return {partial, data};
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        byte_q, byte_d;
  logic [23:0]       word_q, word_d;

  logic              src_ready_q, src_ready_d;
  logic              boot_up_q, boot_up_d;
  logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
  logic [31:0]       boot_datai_q, boot_datai_d;
  logic              boot_web_q, boot_web_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
  logic              err_q, err_d;
`endif

  logic              accept_s;
  logic [31:0]       packed_s;

  assign accept_s = bus.src_valid && src_ready_q;
  assign packed_s = pack_byte(word_q, bus.src_data);

  // State, datapath and registered outputs; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      byte_q       <= 2'd0;
      word_q       <= 24'd0;
      src_ready_q  <= 1'b0;
      boot_up_q    <= 1'b0;
      boot_addr_q  <= '0;
      boot_datai_q <= 32'd0;
      boot_web_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= 32'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      word_q       <= word_d;
      src_ready_q  <= src_ready_d;
      boot_up_q    <= boot_up_d;
      boot_addr_q  <= boot_addr_d;
      boot_datai_q <= boot_datai_d;
      boot_web_q   <= boot_web_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next state, datapath updates, and outputs decoded from the next state so they register in step.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    word_d       = word_q;
    boot_addr_d  = boot_addr_q;
    boot_datai_d = boot_datai_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef BOOT_CHECKSUM_EN
          err_d = 1'b0;
`endif
          if (load_len_i == '0) begin
            state_d = ST_FINISH;
          end else begin
            len_d   = load_len_i;
            addr_d  = '0;
            cnt_d   = '0;
            byte_d  = 2'd0;
            word_d  = 24'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = 32'd0;
`endif
            state_d = ST_ASSEMBLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ASSEMBLE: begin
        if (accept_s) begin
          word_d = packed_s[23:0];
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            boot_addr_d  = addr_q;
            boot_datai_d = packed_s;
            state_d      = ST_WRITE;
          end else begin
            state_d = ST_ASSEMBLE;
          end
        end else begin
          state_d = ST_ASSEMBLE;
        end
      end

      ST_WRITE: begin
        // Address may roll over only after the final word; the load ends there.
        addr_d = addr_q + ADDR_ONE;
        cnt_d  = cnt_q + LEN_ONE;
        byte_d = 2'd0;
`ifdef BOOT_CHECKSUM_EN
        csum_d = csum_q ^ boot_datai_q;
`endif
        if (cnt_d == len_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d = ST_ASSEMBLE;
        end
      end

`ifdef BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          word_d = packed_s[23:0];
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            err_d   = (packed_s != csum_q);
            state_d = ST_FINISH;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef BOOT_CHECKSUM_EN
    src_ready_d = (state_d == ST_ASSEMBLE) || (state_d == ST_CHECK);
    boot_up_d   = (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
`else
    src_ready_d = (state_d == ST_ASSEMBLE);
    boot_up_d   = (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE);
`endif
    boot_web_d  = (state_d != ST_WRITE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FINISH);
  end

  assign bus.src_ready  = src_ready_q;
  assign bus.boot_up    = boot_up_q;
  assign bus.boot_addr  = boot_addr_q;
  assign bus.boot_datai = boot_datai_q;
  assign bus.boot_web   = boot_web_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
`ifdef BOOT_CHECKSUM_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule

// File: doc/boot_loader.md
# boot_loader

- Drives the instruction-cache boot port (`boot_up`, `boot_addr`, `boot_datai`, `boot_web`) of the vector-processor top.
- Receives a byte stream from an external host over a valid/ready handshake.
- Assembles each group of four bytes into a 32-bit instruction and writes it into consecutive icache words starting at address 0.
- Holds `boot_up` high for the whole load; the processor stays in reset until the last write completes.

## Interface
Parameters:
- `ADDR_W`, 8, icache word-address width; max load = 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a load; ignored unless IDLE.
- `load_len`  in  ADDR_W+1  number of words to load, sampled on accepted `start`; legal 0..2^ADDR_W.
- `src_valid`  in  1  host byte valid.
- `src_data`  in  8  host byte.
- `src_ready`  out  1  loader can accept a byte.
- `boot_up`  out  1  high while a load is in progress.
- `boot_addr`  out  ADDR_W  icache word address.
- `boot_datai`  out  32  icache write data.
- `boot_web`  out  1  icache write enable, active low.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at load completion.
- `err`  out  1  checksum mismatch flag; see Configuration.

## Operation
- States: IDLE, ASSEMBLE, WRITE, CHECK (macro only), FINISH.
- IDLE: on `start`:
  - `load_len`==0: go to FINISH; no write occurs.
  - otherwise: latch length, clear address, byte count and checksum, go to ASSEMBLE.
- ASSEMBLE:
  - `src_ready`=1.
  - A byte is accepted when `src_valid`&&`src_ready`; big-endian packing, first byte to [31:24], fourth byte to [7:0].
  - After the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - `boot_web`=0, `boot_addr`=current address, `boot_datai`=assembled word, `src_ready`=0.
  - Next: address+1, words_written+1.
  - If words_written reaches `load_len`: go to CHECK (macro) or FINISH; otherwise go to ASSEMBLE.
- FINISH (one cycle): `done`=1, `boot_up`=0, then go to IDLE.
- `boot_up`=1 in ASSEMBLE, WRITE and CHECK; 0 in IDLE and FINISH.
- Address never wraps: at length 2^ADDR_W the last write is to address 2^ADDR_W-1 and the load ends there.
- `start` while busy is ignored, and a new `load_len` has no effect mid-load.
- `src_valid` while `src_ready`=0 is not consumed; the byte is held by the host.

## Timing
- Reset values: `boot_up`=0, `boot_web`=1, `boot_addr`=0, `boot_datai`=0, `src_ready`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- All outputs are registered.
- `boot_addr` and `boot_datai` are stable in the WRITE cycle and hold their values until the next WRITE.
- `start` at edge N: `src_ready`=1 and `boot_up`=1 from cycle N+1.
- Minimum throughput is 5 cycles per word (4 accept cycles + 1 WRITE).
- `done` is asserted the cycle after the last WRITE (without the macro).
- Reset mid-load: all outputs immediately return to their reset values; any partial word is discarded; no write is issued.
- `err` holds its value until the next accepted `start`, which clears it.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - A running XOR of all written words is kept.
  - After the last WRITE, CHECK accepts 4 more bytes (`src_ready`=1, same packing).
  - If the received word != running XOR, `err` is set in the cycle FINISH is entered.
  - `done` is still pulsed.
- Not defined:
  - No CHECK state; ASSEMBLE/WRITE go directly to FINISH.
  - `err` is tied 0.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values, `src_ready`=0, no `boot_web` low.
- `start`, `load_len`=2, bytes 01 02 03 04 05 06 07 08 with `src_valid` always high -> writes addr0=0x01020304 and addr1=0x05060708, each `boot_web` low exactly 1 cycle, `done` pulse 11 cycles after `start`, `boot_up` high for cycles 1..10.
- `load_len`=0 -> `done` the cycle after `start`, `boot_up` never high, no write.
- `load_len`=256 with random `src_valid` gaps -> 256 writes to addresses 0..255 with matching data, no wrap to 0, one `done`.
- Assert `rst_n`=0 after 2 bytes of word 3 -> outputs return to reset values immediately; a fresh load of 1 word writes to addr 0.
- With `BOOT_CHECKSUM_EN`, words 0x11111111 and 0x22222222 followed by checksum 0x33333333 -> `err`=0; repeat with checksum 0x33333334 -> `err`=1; next `start` clears `err`.
